bnn_window_serializer: RTL and testbench

- Upstream feeder of the 1-bit serial accumulator (shift_adder) in the PIM binary-conv datapath.
- Accepts one K×K activation window plus a weight vector per handshake and emits one product bit per clock.
- Bit timing is phase-locked to the accumulator's free-running window counter, so the accumulator's 4-bit out holds a complete window sum exactly when sum_valid is high.
- Double-buffered so back-to-back windows stream without bubbles.

---
 rtl/pim_pkg.sv | 35 +++
 rtl/bnn_phase_ctr.sv | 47 ++++
 rtl/bnn_window_serializer.sv | 130 +++++++++++++
 tb/tb_bnn_window_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pim_pkg (package)
//  Description : Shared constants, types and helpers for the PIM binary-conv
//                datapath stages that run in lockstep with shift_adder.
//                  KERNAL_DEFAULT  default kernel edge size
//                  win_len(k)      window length k*k
//                  PH_W_DEFAULT    phase counter width (2**PH_W >= window)
//                  win_vec_t       one window's worth of binary values
//                  buf_entry_t     {act, wgt, vld} window buffer entry
//  Revision    : 1.0  initial release
// ============================================================================
package pim_pkg;

    localparam int KERNAL_DEFAULT = 3;

    function automatic int win_len(input int k);
        return k * k;
    endfunction

    localparam int WIN_LEN_DEFAULT = win_len(KERNAL_DEFAULT);

    // Must cover 0..N-1; the downstream 4-bit accumulator caps N at 15.
    localparam int PH_W_DEFAULT = 4;

    typedef logic [WIN_LEN_DEFAULT-1:0] win_vec_t;

    typedef struct packed {
        win_vec_t act;
        win_vec_t wgt;
        logic     vld;
    } buf_entry_t;

endpackage : pim_pkg
`default_nettype wire

// File: rtl/bnn_phase_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_phase_ctr
//  Description : Free-running 0..N-1 window phase counter that mirrors the
//                shift_adder window counter (same clk, same rst), plus the
//                strobes derived from it.
//  Ports       : clk          clock
//                rst          asynchronous active-high reset
//                o_phase      current phase, 0..N-1
//                o_swap       high at phase N-2 (next edge is the swap edge)
//                o_win_start  high at phase N-1
//  Revision    : 1.0  initial release
// ============================================================================
module bnn_phase_ctr
    import pim_pkg::*;
#(
    parameter int N    = WIN_LEN_DEFAULT,
    parameter int PH_W = PH_W_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    output logic [PH_W-1:0] o_phase,
    output logic            o_swap,
    output logic            o_win_start
);

    localparam logic [PH_W-1:0] c_LAST = PH_W'(N - 1);
    localparam logic [PH_W-1:0] c_PRE  = PH_W'(N - 2);

    logic [PH_W-1:0] r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (r_phase == c_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    assign o_phase     = r_phase;
    assign o_swap      = (r_phase == c_PRE);
    assign o_win_start = (r_phase == c_LAST);

endmodule : bnn_phase_ctr
`default_nettype wire

// File: rtl/bnn_window_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_window_serializer
//  Description : Accepts one KxK binary activation window plus weight vector
//                per valid/ready handshake and serialises the element-wise
//                product, one bit per clock, phase-locked to the downstream
//                shift_adder window counter. A pending + active buffer pair
//                lets back-to-back windows stream without bubbles.
//  Build macro : PIM_XNOR_MODE_EN  product = ~(act ^ wgt) (+/-1 encoding);
//                                  undefined: product = act & wgt.
//  Ports       : clk        clock
//                rst        asynchronous active-high reset
//                win_valid  producer offers a window
//                win_ready  window accepted this edge if win_valid is high
//                act        activations, bit i = element i (row-major)
//                wgt        weights, same ordering
//                bit_out    product bit, drives shift_adder.in
//                win_start  bit_out carries element 0 of a window
//                sum_valid  shift_adder.out holds a complete real window sum
//                underrun   one-cycle pulse: a window slot began with no data
//  Revision    : 1.0  initial release
// ============================================================================
module bnn_window_serializer
    import pim_pkg::*;
#(
    parameter int kernal = KERNAL_DEFAULT,
    parameter int PH_W   = PH_W_DEFAULT
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [kernal*kernal-1:0] act,
    input  logic [kernal*kernal-1:0] wgt,
    output logic                     bit_out,
    output logic                     win_start,
    output logic                     sum_valid,
    output logic                     underrun
);

    localparam int N = win_len(kernal);

    typedef struct packed {
        logic [N-1:0] act;
        logic [N-1:0] wgt;
        logic         vld;
    } entry_t;

    logic [PH_W-1:0] w_phase;
    logic            w_swap;
    logic            w_win_start;
    logic            w_accept;
    logic [PH_W-1:0] w_idx;
    logic [N-1:0]    w_prod_vec;

    entry_t r_pend;
    entry_t r_act;
    logic   r_done_vld;
    logic   r_armed;
    logic   r_underrun;
    logic   r_alive;

    bnn_phase_ctr #(
        .N    (N),
        .PH_W (PH_W)
    ) u_phase_ctr (
        .clk         (clk),
        .rst         (rst),
        .o_phase     (w_phase),
        .o_swap      (w_swap),
        .o_win_start (w_win_start)
    );

    // r_alive holds off the handshake until the first edge after reset so
    // that nothing is accepted while the phase counter is still in reset.
    assign win_ready = r_alive & (~r_pend.vld | w_swap);
    assign w_accept  = win_valid & win_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_act      <= '0;
            r_done_vld <= 1'b0;
            r_armed    <= 1'b0;
            r_underrun <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_alive <= 1'b1;

            // Swap edge: pending (possibly empty) becomes the active window;
            // the window that just finished is remembered for sum_valid.
            if (w_swap) begin
                r_act      <= r_pend;
                r_done_vld <= r_act.vld;
                r_underrun <= r_armed & ~r_pend.vld;
            end else begin
                r_underrun <= 1'b0;
            end

            // A transfer on the swap edge refills pending right behind the
            // window that is moving to active, so ordering is preserved.
            if (w_accept) begin
                r_pend.act <= act;
                r_pend.wgt <= wgt;
                r_pend.vld <= 1'b1;
                r_armed    <= 1'b1;
            end else if (w_swap) begin
                r_pend.vld <= 1'b0;
            end
        end
    end

    // Element presented this cycle: element 0 at phase N-1 so that the
    // accumulator's window boundary lines up with ours.
    assign w_idx = w_win_start ? '0 : (w_phase + PH_W'(1));

`ifdef PIM_XNOR_MODE_EN
    assign w_prod_vec = ~(r_act.act ^ r_act.wgt);
`else
    assign w_prod_vec = r_act.act & r_act.wgt;
`endif

    // An empty active slot always emits 0, in either product encoding.
    assign bit_out   = r_act.vld & w_prod_vec[w_idx];
    assign win_start = w_win_start;
    assign sum_valid = w_win_start & r_done_vld;
    assign underrun  = r_underrun;

endmodule : bnn_window_serializer
`default_nettype wire

// File: tb/tb_bnn_window_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_window_serializer
//  Description : Self-checking bench. A window-level model (slot queue,
//                phase count, popcount sums) predicts every output each
//                cycle; a bench-side shift_adder accumulates bit_out so the
//                reported window sums can be checked against the model and
//                against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bnn_window_serializer;
    import pim_pkg::*;

    localparam int N = win_len(KERNAL_DEFAULT);

    logic         clk = 1'b0;
    logic         rst;
    logic         win_valid;
    logic [N-1:0] act;
    logic [N-1:0] wgt;
    logic         win_ready;
    logic         bit_out;
    logic         win_start;
    logic         sum_valid;
    logic         underrun;

    bnn_window_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .act       (act),
        .wgt       (wgt),
        .bit_out   (bit_out),
        .win_start (win_start),
        .sum_valid (sum_valid),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    int           m_ph;
    buf_entry_t   m_cur;
    buf_entry_t   m_fin;
    buf_entry_t   m_q[$];
    logic         m_done;
    logic         m_armed;
    logic         m_und;
    logic         m_alive;
    logic         last_acc;
    int           acc_sum;
    int           sum_log[$];
    logic [N-1:0] bits_log[$];
    logic [N-1:0] cap;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    function automatic logic prod(input buf_entry_t e, input int i);
`ifdef PIM_XNOR_MODE_EN
        return e.vld & ~(e.act[i] ^ e.wgt[i]);
`else
        return e.vld & e.act[i] & e.wgt[i];
`endif
    endfunction

    function automatic int wsum(input buf_entry_t e);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(prod(e, i));
        return s;
    endfunction

    function automatic logic exp_ready();
        return m_alive && (m_q.size() == 0 || m_ph == N - 2);
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cur = '0; m_fin = '0; m_q.delete();
        m_done = 0; m_armed = 0; m_und = 0; m_alive = 0; last_acc = 0;
        acc_sum = 0; sum_log.delete(); bits_log.delete(); cap = '0;
    endtask

    // Compare all outputs against the model (called between edges).
    task automatic sample();
        int idx = (m_ph == N - 1) ? 0 : m_ph + 1;
        chk("bit_out",   int'(bit_out),   int'(prod(m_cur, idx)));
        chk("win_start", int'(win_start), int'(m_ph == N - 1));
        chk("sum_valid", int'(sum_valid), int'(m_ph == N - 1 && m_done));
        chk("underrun",  int'(underrun),  int'(m_und));
        chk("win_ready", int'(win_ready), int'(exp_ready()));
        if (m_ph == N - 1 && m_done) begin
            chk("window_sum", acc_sum, wsum(m_fin));
            sum_log.push_back(acc_sum);
        end
        if (m_ph == N - 1) acc_sum = int'(bit_out);
        else               acc_sum += int'(bit_out);
        if (m_cur.vld) begin
            cap[idx] = bit_out;
            if (m_ph == N - 2) bits_log.push_back(cap);
        end
    endtask

    // Advance the model across one clock edge.
    task automatic edge_update();
        logic acc = exp_ready() && win_valid;
        if (m_ph == N - 2) begin
            m_und  = m_armed && (m_q.size() == 0);
            m_done = m_cur.vld;
            m_fin  = m_cur;
            m_cur  = (m_q.size() != 0) ? m_q.pop_front() : '0;
        end else begin
            m_und = 0;
        end
        if (acc) begin
            m_q.push_back('{act: act, wgt: wgt, vld: 1'b1});
            m_armed = 1;
        end
        m_ph     = (m_ph + 1) % N;
        m_alive  = 1;
        last_acc = acc;
    endtask

    task automatic cycle(input logic v, input logic [N-1:0] a, input logic [N-1:0] w);
        win_valid = v; act = a; wgt = w;
        @(posedge clk);
        edge_update();
        @(negedge clk);
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, N'($urandom), N'($urandom));
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] w);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle(1'b1, a, w);
            ok = last_acc;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        win_valid = 0;
    endtask

    // Called at a negedge; asserts reset asynchronously and checks the
    // outputs clear immediately.
    task automatic do_reset();
        rst = 1; win_valid = 0;
        #1;
        chk("rst_bit_out",   int'(bit_out),   0);
        chk("rst_win_start", int'(win_start), 0);
        chk("rst_sum_valid", int'(sum_valid), 0);
        chk("rst_underrun",  int'(underrun),  0);
        chk("rst_win_ready", int'(win_ready), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        sample();
    endtask

    task automatic chk_sum(input string nm, input int k, input int exp);
        chk(nm, (sum_log.size() > k) ? sum_log[k] : -1, exp);
    endtask

    task automatic chk_bits(input string nm, input int k, input int exp);
        chk(nm, (bits_log.size() > k) ? int'(bits_log[k]) : -1, exp);
    endtask

    task automatic scenario_single();
        send(9'h1FF, 9'h0AA);
        idle(30);
        // 0xAA pattern both ways: AND gives 0AA, XNOR(1FF,0AA) is also 0AA.
        chk_bits("s1_bits", 0, 'h0AA);
        chk_sum("s1_sum", 0, 4);
    endtask

    initial begin
        rst = 1; win_valid = 0; act = '0; wgt = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Single window, then underrun on the empty slot.
        do_reset();
        scenario_single();

        // Back-to-back: second window accepted on the swap edge.
        do_reset();
        send(9'h1FF, 9'h1FF);
        send(9'h1FF, 9'h000);
        idle(30);
        chk_sum("s2_sum0", 0, 9);
        chk_sum("s2_sum1", 1, 0);

        // Reset at phase 4 of a loaded window.
        do_reset();
        send(9'h1FF, 9'h0AA);
        begin
            bit hit = 0;
            for (int i = 0; i < 40 && !hit; i++) begin
                if (m_cur.vld && m_ph == 4) hit = 1;
                else cycle(1'b0, '0, '0);
            end
            if (!hit) chk("phase4_timeout", 0, 1);
        end
        do_reset();
        idle(20);
        chk("abort_no_sum", sum_log.size(), 0);
        scenario_single();

        // Encoding check: all-zero window, then 1FF/000.
        do_reset();
        send(9'h000, 9'h000);
        send(9'h1FF, 9'h000);
        idle(30);
`ifdef PIM_XNOR_MODE_EN
        chk_sum("enc_sum0", 0, 9);
`else
        chk_sum("enc_sum0", 0, 0);
`endif
        chk_sum("enc_sum1", 1, 0);

        // Randomised traffic with bursty valid.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int dens = ((i / 200) % 3 == 1) ? 20 : 85;
            cycle(($urandom_range(0, 99) < dens), N'($urandom), N'($urandom));
        end
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_bnn_window_serializer
`default_nettype wire
